unpack_sequencer: RTL

- Scheduler that time-shares one combinational Unpacker instance between the two source operands (FA, FB) of an FPU operation.
- Accepts an operation request on a valid/ready handshake and drives the Unpacker with FA, then FB. Unary operations drive FA only.
- Registers each Unpacker result (lz, f, fz, h) and presents both unpacked operands to the next FPU stage on a second valid/ready handshake.
- Derives the Unpacker's ez input from the operand's exponent field.

---
 rtl/unpack_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/unpack_sequencer.sv
// Time-shares one combinational Unpacker between the FA and FB operands of an FPU op,
// capturing each result and presenting both on a valid/ready handshake.
//
// state  | meaning
// IDLE   | no operation in flight, ready for a request
// UNP_A  | FA on the Unpacker bus, result captured into a_* at the edge
// UNP_B  | FB on the Unpacker bus, result captured into b_* at the edge
// DONE   | results presented with out_valid, held until out_ready
module unpack_sequencer #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dbs,
  input  logic         in_unary,
  input  logic         in_normal,
  input  logic [N-1:0] in_fa,
  input  logic [N-1:0] in_fb,
  output logic         up_dbs,
  output logic [N-1:0] up_x,
  output logic         up_ez,
  output logic         up_normal,
  input  logic [5:0]   up_lz,
  input  logic [52:0]  up_f,
  input  logic         up_fz,
  input  logic [51:0]  up_h,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_dbs,
  output logic         out_unary,
  output logic [5:0]   a_lz,
  output logic [52:0]  a_f,
  output logic         a_fz,
  output logic [51:0]  a_h,
  output logic [5:0]   b_lz,
  output logic [52:0]  b_f,
  output logic         b_fz,
  output logic [51:0]  b_h
);

  typedef enum logic [1:0] {IDLE, UNP_A, UNP_B, DONE} state_t;

  state_t       state;
  logic [N-1:0] r_fa;
  logic [N-1:0] r_fb;
  logic         r_dbs;
  logic         r_unary;
  logic         r_normal;
  logic         accept;
  logic         unp_active;

  assign in_ready   = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept     = in_valid & in_ready;
  assign unp_active = (state == UNP_A) | (state == UNP_B);

  // Bus is held at zero outside the UNP cycles so the Unpacker sees a quiet input.
  always_comb begin
    up_x      = '0;
    up_dbs    = 1'b0;
    up_normal = 1'b0;
    up_ez     = 1'b0;
    if (unp_active) begin
      up_x      = (state == UNP_A) ? r_fa : r_fb;
      up_dbs    = r_dbs;
      up_normal = r_normal;
      up_ez     = r_dbs ? (up_x[62:52] == 11'd0) : (up_x[62:55] == 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      r_fa      <= '0;
      r_fb      <= '0;
      r_dbs     <= 1'b0;
      r_unary   <= 1'b0;
      r_normal  <= 1'b0;
      out_dbs   <= 1'b0;
      out_unary <= 1'b0;
      a_lz      <= '0;
      a_f       <= '0;
      a_fz      <= 1'b0;
      a_h       <= '0;
      b_lz      <= '0;
      b_f       <= '0;
      b_fz      <= 1'b0;
      b_h       <= '0;
    end else begin
      case (state)
        IDLE: ;
        UNP_A: begin
          a_lz <= up_lz;
          a_f  <= up_f;
          a_fz <= up_fz;
          a_h  <= up_h;
          if (r_unary) begin
            b_lz      <= '0;
            b_f       <= '0;
            b_fz      <= 1'b0;
            b_h       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            state <= UNP_B;
          end
        end
        UNP_B: begin
          b_lz      <= up_lz;
          b_f       <= up_f;
          b_fz      <= up_fz;
          b_h       <= up_h;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Accepting from DONE overrides the IDLE transition, giving back-to-back ops.
      if (accept) begin
        r_fa      <= in_fa;
        r_fb      <= in_fb;
        r_dbs     <= in_dbs;
        r_unary   <= in_unary;
        r_normal  <= in_normal;
        out_dbs   <= in_dbs;
        out_unary <= in_unary;
        state     <= UNP_A;
      end
    end
  end

endmodule
